shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/alu_pkg.sv | 21 ++
 rtl/shift_step.sv | 70 +++++++
 rtl/shift_sequencer.sv | 130 +++++++++++++
 tb/tb_shift_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the shift sequencer datapath.
//   WORD_W / SHAMT_W : operand and shift-amount widths
//   SH_LL/SH_RL/SH_RA/SH_RSV : encodings of the 2-bit shift kind (dir)
//   state_e          : sequencer FSM state type
package alu_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned SHAMT_W = 5;

  localparam logic [1:0] SH_LL  = 2'b00;  // logical left, zero fill
  localparam logic [1:0] SH_RL  = 2'b01;  // logical right, zero fill
  localparam logic [1:0] SH_RA  = 2'b10;  // arithmetic right, sign fill
  localparam logic [1:0] SH_RSV = 2'b11;  // reserved, flagged as error

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter.
// Shifts by one bit, or by four bits when by4 is set (by4 exists only when
// SHIFT_FAST_EN is defined).
// Ports:
//   by4    : select a 4-bit step (SHIFT_FAST_EN builds only)
//   data   : current working word
//   kind   : shift kind (SH_LL / SH_RL / SH_RA / SH_RSV)
//   result : shifted word
//   carry  : last bit shifted out by this step
module shift_step
  import alu_pkg::*;
(
`ifdef SHIFT_FAST_EN
  input  logic              by4,
`endif
  input  logic [WORD_W-1:0] data,
  input  logic [1:0]        kind,
  output logic [WORD_W-1:0] result,
  output logic              carry
);

  always_comb begin
    result = data;
    carry  = 1'b0;
`ifdef SHIFT_FAST_EN
    if (by4) begin
      unique case (kind)
        SH_LL: begin
          result = {data[WORD_W-5:0], 4'b0000};
          carry  = data[WORD_W-4];
        end
        SH_RL: begin
          result = {4'b0000, data[WORD_W-1:4]};
          carry  = data[3];
        end
        SH_RA: begin
          result = {{4{data[WORD_W-1]}}, data[WORD_W-1:4]};
          carry  = data[3];
        end
        SH_RSV: begin
          result = data;
          carry  = 1'b0;
        end
      endcase
    end else begin
`endif
      unique case (kind)
        SH_LL: begin
          result = {data[WORD_W-2:0], 1'b0};
          carry  = data[WORD_W-1];
        end
        SH_RL: begin
          result = {1'b0, data[WORD_W-1:1]};
          carry  = data[0];
        end
        SH_RA: begin
          result = {data[WORD_W-1], data[WORD_W-1:1]};
          carry  = data[0];
        end
        SH_RSV: begin
          result = data;
          carry  = 1'b0;
        end
      endcase
`ifdef SHIFT_FAST_EN
    end
`endif
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift sequencer feeding the ALU bit-slices.
// Latches an operand on start, shifts it one bit per cycle (or four bits
// per cycle while at least four remain, when SHIFT_FAST_EN is defined), and
// pulses done once the result is ready.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   start    : request an operation (honoured only when idle)
//   data_in  : operand
//   shamt    : shift amount 0..31
//   dir      : shift kind (00 shll, 01 shrl, 10 shra, 11 reserved)
//   busy     : operation in progress (SHIFT or DONE)
//   done     : one-cycle completion pulse
//   sh_out   : working register / final result
//   sh_carry : last bit shifted out
//   err      : reserved dir value, asserted with done
// Configuration macro: SHIFT_FAST_EN
module shift_sequencer
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WORD_W-1:0]  data_in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         dir,
  output logic               busy,
  output logic               done,
  output logic [WORD_W-1:0]  sh_out,
  output logic               sh_carry,
  output logic               err
);

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   work_q;
  logic [SHAMT_W-1:0]  cnt_q;
  logic [1:0]          kind_q;
  logic                carry_q;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [WORD_W-1:0]   step_result;
  logic                step_carry;
  logic [SHAMT_W-1:0]  step_amt;

`ifdef SHIFT_FAST_EN
  logic by4;
  assign by4      = (cnt_q >= SHAMT_W'(4));
  assign step_amt = by4 ? SHAMT_W'(4) : SHAMT_W'(1);
`else
  assign step_amt = SHAMT_W'(1);
`endif

  shift_step u_shift_step (
`ifdef SHIFT_FAST_EN
    .by4    (by4),
`endif
    .data   (work_q),
    .kind   (kind_q),
    .result (step_result),
    .carry  (step_carry)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = ((shamt != '0) && (dir != SH_RSV)) ? StShift : StDone;
        end
      end
      StShift: begin
        // Leave on the step that drains the remaining count.
        if (cnt_q == step_amt) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic; done/err are registered so the pulse lands one cycle after DONE
  always_comb begin
    busy   = (state_q != StIdle);
    done_d = (state_q == StDone);
    err_d  = (state_q == StDone) && (kind_q == SH_RSV);
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      work_q  <= '0;
      cnt_q   <= '0;
      kind_q  <= SH_LL;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= done_d;
      err_q  <= err_d;
      if ((state_q == StIdle) && start) begin
        work_q  <= data_in;
        cnt_q   <= shamt;
        kind_q  <= dir;
        carry_q <= 1'b0;
      end else if (state_q == StShift) begin
        work_q  <= step_result;
        carry_q <= step_carry;
        cnt_q   <= cnt_q - step_amt;
      end
    end
  end

  assign done     = done_q;
  assign err      = err_q;
  assign sh_out   = work_q;
  assign sh_carry = carry_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed operations push their
// expected result and completion cycle into a queue; a monitor pops and
// compares on every done pulse.
module tb_shift_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic [1:0]  dir;
  logic        busy;
  logic        done;
  logic [31:0] sh_out;
  logic        sh_carry;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int popped = 0;
  int pushed = 0;

  typedef struct {
    logic [31:0] out;
    logic        c;
    logic        e;
    int          at;
    string       name;
  } exp_t;

  exp_t sb[$];

  shift_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data_in  (data_in),
    .shamt    (shamt),
    .dir      (dir),
    .busy     (busy),
    .done     (done),
    .sh_out   (sh_out),
    .sh_carry (sh_carry),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int s, input logic [1:0] k);
    if (k == 2'b11 || s == 0) return 0;
`ifdef SHIFT_FAST_EN
    return s / 4 + s % 4;
`else
    return s;
`endif
  endfunction

  // Monitor: every done pulse must match the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check({e.name, "_out"},   sh_out,          e.out);
          check({e.name, "_carry"}, {31'd0, sh_carry}, {31'd0, e.c});
          check({e.name, "_err"},   {31'd0, err},    {31'd0, e.e});
          check({e.name, "_cycle"}, cyc,             e.at);
          check({e.name, "_busy"},  {31'd0, busy},   32'd0);
          popped++;
        end
      end
    end
  end

  // Issue one operation; hold > 0 keeps start asserted (with other data)
  // for that many extra cycles while the sequencer is busy.
  task automatic launch(input string name, input logic [31:0] d, input logic [4:0] s,
                        input logic [1:0] k, input logic [31:0] eo, input logic ec,
                        input logic ee, input int hold);
    exp_t e;
    @(negedge clk);
    data_in = d;
    shamt   = s;
    dir     = k;
    start   = 1'b1;
    @(negedge clk);
    // cyc now equals the edge that sampled start
    e.out  = eo;
    e.c    = ec;
    e.e    = ee;
    e.at   = cyc + lat_of(int'(s), k) + 1;
    e.name = name;
    sb.push_back(e);
    pushed++;
    check({name, "_busy_after_start"}, {31'd0, busy}, 32'd1);
    if (hold > 0) begin
      data_in = 32'h5555_AAAA;
      shamt   = 5'd2;
      dir     = 2'b00;
      repeat (hold) @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic wait_all(input string name);
    int n = 0;
    while (popped < pushed && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (popped < pushed) begin
      check({name, "_timeout"}, 32'd1, 32'd0);
      sb.delete();
      popped = pushed;
    end
  endtask

  initial begin
    start   = 1'b0;
    data_in = '0;
    shamt   = '0;
    dir     = '0;
    rst     = 1'b0;
    #1;
    check("rst_sh_out",   sh_out,            32'd0);
    check("rst_busy",     {31'd0, busy},     32'd0);
    check("rst_done",     {31'd0, done},     32'd0);
    check("rst_carry",    {31'd0, sh_carry}, 32'd0);
    check("rst_err",      {31'd0, err},      32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    launch("ll4",    32'h0000_0001, 5'd4,  2'b00, 32'h0000_0010, 1'b0, 1'b0, 0);
    wait_all("ll4");
    launch("ra3",    32'h8000_0000, 5'd3,  2'b10, 32'hF000_0000, 1'b0, 1'b0, 0);
    wait_all("ra3");
    launch("rl3",    32'h8000_0000, 5'd3,  2'b01, 32'h1000_0000, 1'b0, 1'b0, 0);
    wait_all("rl3");
    launch("sh0",    32'hDEAD_BEEF, 5'd0,  2'b00, 32'hDEAD_BEEF, 1'b0, 1'b0, 0);
    wait_all("sh0");
    launch("rsv",    32'h1234_5678, 5'd7,  2'b11, 32'h1234_5678, 1'b0, 1'b1, 0);
    wait_all("rsv");
    launch("rl9",    32'hFFFF_FFFF, 5'd9,  2'b01, 32'h007F_FFFF, 1'b1, 1'b0, 0);
    wait_all("rl9");
    launch("ll1",    32'h8000_0001, 5'd1,  2'b00, 32'h0000_0002, 1'b1, 1'b0, 0);
    wait_all("ll1");
    launch("ll31",   32'h0000_0003, 5'd31, 2'b00, 32'h8000_0000, 1'b1, 1'b0, 0);
    wait_all("ll31");
    launch("ra5",    32'hA5A5_A5A5, 5'd5,  2'b10, 32'hFD2D_2D2D, 1'b0, 1'b0, 0);
    wait_all("ra5");

    // start held through SHIFT and DONE must not queue a second operation
    launch("busy_ign", 32'h0000_0001, 5'd10, 2'b00, 32'h0000_0400, 1'b0, 1'b0,
           lat_of(10, 2'b00) + 1);
    wait_all("busy_ign");
    repeat (10) @(negedge clk);
    check("hold_result", sh_out, 32'h0000_0400);

    // Reset mid-SHIFT: outputs clear at once and no done follows
    @(negedge clk);
    data_in = 32'hFFFF_0000;
    shamt   = 5'd20;
    dir     = 2'b01;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("abort_sh_out", sh_out,            32'd0);
    check("abort_busy",   {31'd0, busy},     32'd0);
    check("abort_done",   {31'd0, done},     32'd0);
    check("abort_carry",  {31'd0, sh_carry}, 32'd0);
    check("abort_err",    {31'd0, err},      32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);

    // Resumes normally after reset
    launch("post_rst", 32'h0000_00F0, 5'd4, 2'b01, 32'h0000_000F, 1'b0, 1'b0, 0);
    wait_all("post_rst");
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
